// File: rtl/sram_master.sv
// MEM-stage initiator for the single-port data SRAM: sequences read, write and
// read-modify-write strobes for one load/store request at a time.
module sram_master #(
  parameter int ADDR_W   = 10,
  parameter int READ_LAT = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [31:0]       resp_rdata,
  output logic              resp_err,
  output logic              CSram,
  output logic [7:0]        Direc,
  output logic [31:0]       Datain,
  output logic              LeerMem,
  output logic              EscrMem,
  input  logic [31:0]       Dataout
);

  localparam logic [2:0] IDLE = 3'd0;
  localparam logic [2:0] CHK  = 3'd1;
  localparam logic [2:0] RD   = 3'd2;
  localparam logic [2:0] WAIT = 3'd3;
  localparam logic [2:0] WR   = 3'd4;
  localparam logic [2:0] RESP = 3'd5;

  localparam logic [1:0] LAST_WAIT = 2'(READ_LAT - 1);

  logic [2:0]        state;
  logic [2:0]        state_next;
  logic [1:0]        wait_cnt;
  logic              we_q;
  logic [1:0]        size_q;
  logic              uns_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       wdata_q;
  logic              req_err;
  logic [7:0]        byte_v;
  logic [15:0]       half_v;
  logic [31:0]       load_data;
  logic [31:0]       merged;

  assign req_ready = (state == IDLE);

  always_comb begin
    req_err = (size_q == 2'b11) ||
              (size_q == 2'b01 && addr_q[0]) ||
              (size_q == 2'b10 && addr_q[1:0] != 2'b00);
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (req_valid) state_next = CHK;
      CHK: begin
        if (req_err)                       state_next = RESP;
        else if (we_q && size_q == 2'b10)  state_next = WR;
        else                               state_next = RD;
      end
      RD:   state_next = WAIT;
      WAIT: if (wait_cnt == LAST_WAIT) state_next = we_q ? WR : RESP;
      WR:   state_next = RESP;
      RESP: if (resp_valid && resp_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Lane extraction for loads and lane merge for sub-word stores both work on
  // the word arriving on Dataout at the end of the last WAIT cycle.
  always_comb begin
    byte_v    = Dataout[{addr_q[1:0], 3'b000} +: 8];
    half_v    = Dataout[{addr_q[1], 4'b0000} +: 16];
    load_data = Dataout;
    merged    = wdata_q;
    case (size_q)
      2'b00: begin
        load_data = {{24{~uns_q & byte_v[7]}}, byte_v};
        merged    = Dataout;
        merged[{addr_q[1:0], 3'b000} +: 8] = wdata_q[7:0];
      end
      2'b01: begin
        load_data = {{16{~uns_q & half_v[15]}}, half_v};
        merged    = Dataout;
        merged[{addr_q[1], 4'b0000} +: 16] = wdata_q[15:0];
      end
      default: ;
    endcase
  end

  // Outputs are registered from the next state so they line up with the state
  // they belong to.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      wait_cnt   <= 2'd0;
      we_q       <= 1'b0;
      size_q     <= 2'b00;
      uns_q      <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= 32'd0;
      CSram      <= 1'b0;
      LeerMem    <= 1'b0;
      EscrMem    <= 1'b0;
      Direc      <= 8'd0;
      Datain     <= 32'd0;
      resp_valid <= 1'b0;
      resp_err   <= 1'b0;
      resp_rdata <= 32'd0;
    end else begin
      state    <= state_next;
      wait_cnt <= (state == WAIT && state_next == WAIT) ? wait_cnt + 2'd1 : 2'd0;
      if (req_valid && req_ready) begin
        we_q    <= req_we;
        size_q  <= req_size;
        uns_q   <= req_unsigned;
        addr_q  <= req_addr;
        wdata_q <= req_wdata;
      end
      CSram   <= (state_next == RD) || (state_next == WR);
      LeerMem <= (state_next == RD);
      EscrMem <= (state_next == WR);
      if (state_next == RD || state_next == WR) Direc <= addr_q[ADDR_W-1:2];
      if (state_next == WR) Datain <= merged;
      resp_valid <= (state_next == RESP);
      if (state != RESP && state_next == RESP) begin
        resp_err   <= (state == CHK);
        resp_rdata <= (state == WAIT) ? load_data : 32'd0;
      end else if (state_next != RESP) begin
        resp_err   <= 1'b0;
        resp_rdata <= 32'd0;
      end
    end
  end

endmodule
